intc_vectored: RTL and testbench

Parametrised vectored interrupt controller that replaces the single `intr` / `Int_en` interrupt path of the control unit with N prioritised sources, per-source masking and bounded nesting. It sits between the external interrupt pins and the fetch-stage control logic. It raises one registered request (`intr`) and presents the winning source's ID and vector address. It tracks in-service interrupts on an internal stack that is pushed on acknowledge and popped on RTI.

---
 rtl/intc_vectored_if.sv | 32 +++
 rtl/intc_vectored.sv | 143 ++++++++++++++
 tb/tb_intc_vectored.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/intc_vectored_if.sv
// intc_vectored_if: interrupt pins, mask port, fetch-CU handshake and status.
// master = fetch CU / pin side, slave = the interrupt controller.
interface intc_vectored_if #(
    parameter int N_SRC      = 4,
    parameter int NEST_DEPTH = 2,
    parameter int VEC_W      = 8
);
    localparam int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);

    logic [N_SRC-1:0] irq_in;
    logic             mask_wr;
    logic [N_SRC-1:0] mask_data;
    logic             int_ack;
    logic             rti;
    logic             intr;
    logic [ID_W-1:0]  int_id;
    logic [VEC_W-1:0] vec_addr;
    logic             in_service;
    logic [LVL_W-1:0] nest_level;
    logic             err;

    modport master (
        output irq_in, mask_wr, mask_data, int_ack, rti,
        input  intr, int_id, vec_addr, in_service, nest_level, err
    );

    modport slave (
        input  irq_in, mask_wr, mask_data, int_ack, rti,
        output intr, int_id, vec_addr, in_service, nest_level, err
    );
endinterface

// File: rtl/intc_vectored.sv
// intc_vectored: prioritised vectored interrupt controller with in-service stack.
// Define INTC_NEST_EN for nesting/preemption; otherwise effective depth is 1.
module intc_vectored #(
    parameter int N_SRC      = 4,
    parameter int NEST_DEPTH = 2,
    parameter int VEC_W      = 8,
    parameter int VEC_BASE   = 0
) (
    input  logic           clk,
    input  logic           rst,
    intc_vectored_if.slave bus
);
    localparam int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);
`ifdef INTC_NEST_EN
    localparam int DEPTH = NEST_DEPTH;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t state_q, state_d;

    logic [N_SRC-1:0]      irq_q;
    logic [N_SRC-1:0]      pend_q;
    logic [N_SRC-1:0]      mask_q;
    logic [N_SRC-1:0]      edge_w;
    logic [N_SRC-1:0]      clr_w;
    logic [N_SRC-1:0]      act_w;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       cand;
    logic [ID_W-1:0]       tos;
    logic                  cand_v;
    logic                  elig;
    logic                  latch;
    logic                  take;
    logic                  pop;
    logic [DEPTH*ID_W-1:0] stk_q;
    logic [LVL_W-1:0]      lvl_q;
    logic                  err_q;
    int                    tos_idx;
    int                    push_idx;

    assign edge_w = bus.irq_in & ~irq_q;
    assign act_w  = pend_q & mask_q;
    assign clr_w  = take ? (N_SRC'(1) << id_q) : '0;
    assign pop    = bus.rti && (lvl_q != '0);

    // Lowest-index enabled pending source wins.
    always_comb begin
        cand   = '0;
        cand_v = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act_w[i]) begin
                cand   = ID_W'(i);
                cand_v = 1'b1;
            end
        end
    end

    // Stack pointers and eligibility (strict preemption against top-of-stack).
    always_comb begin
        tos_idx  = (lvl_q == '0) ? 0 : int'(lvl_q) - 1;
        push_idx = (int'(lvl_q) < DEPTH) ? int'(lvl_q) : DEPTH - 1;
        tos      = stk_q[tos_idx*ID_W +: ID_W];
        elig     = cand_v && (int'(lvl_q) < DEPTH) &&
                   ((lvl_q == '0) || (cand < tos));
    end

    // Request FSM next-state logic.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (elig) begin
                    latch   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    take    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and frozen request ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch) id_q <= cand;
        end
    end

    // Edge detect, pending latch (new edge beats ack clear) and mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q  <= '0;
            pend_q <= '0;
            mask_q <= '1;
        end else begin
            irq_q  <= bus.irq_in;
            pend_q <= (pend_q & ~clr_w) | edge_w;
            if (bus.mask_wr) mask_q <= bus.mask_data;
        end
    end

    // In-service stack: pop on RTI, push on ack, replace top when both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_q <= '0;
            lvl_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (bus.rti && (lvl_q == '0)) err_q <= 1'b1;
            if (take && pop) begin
                stk_q[tos_idx*ID_W +: ID_W] <= id_q;
            end else if (pop) begin
                lvl_q <= lvl_q - LVL_W'(1);
            end else if (take) begin
                stk_q[push_idx*ID_W +: ID_W] <= id_q;
                lvl_q <= lvl_q + LVL_W'(1);
            end
        end
    end

    assign bus.intr       = (state_q == REQ);
    assign bus.int_id     = id_q;
    assign bus.vec_addr   = VEC_W'(VEC_BASE) + VEC_W'(id_q);
    assign bus.in_service = (lvl_q != '0);
    assign bus.nest_level = lvl_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_intc_vectored.sv
// tb_intc_vectored: directed table-driven bench for intc_vectored.
// Builds with or without INTC_NEST_EN; selects the matching nesting table.
module tb_intc_vectored;
    localparam int VEC_BASE = 0;

    typedef struct {
        logic [3:0] irq;
        logic       mwr;
        logic [3:0] md;
        logic       ack;
        logic       rti;
        logic       e_intr;
        logic [1:0] e_id;
        logic [1:0] e_lvl;
        logic       e_err;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t tbl[$];
    vec_t cfg[$];

    intc_vectored_if #(.N_SRC(4), .NEST_DEPTH(2), .VEC_W(8)) bus ();

    intc_vectored #(
        .N_SRC(4), .NEST_DEPTH(2), .VEC_W(8), .VEC_BASE(VEC_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [3:0] irq, input logic mwr, input logic [3:0] md,
        input logic ack, input logic rti,
        input logic ei, input logic [1:0] eid, input logic [1:0] el,
        input logic ee);
        vec_t v;
        v.irq = irq; v.mwr = mwr; v.md = md; v.ack = ack; v.rti = rti;
        v.e_intr = ei; v.e_id = eid; v.e_lvl = el; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ei,
                             input logic [1:0] eid, input logic [1:0] el,
                             input logic ee);
        chk({tag, ".intr"}, 32'(bus.intr), 32'(ei));
        if (ei) begin
            chk({tag, ".int_id"}, 32'(bus.int_id), 32'(eid));
            chk({tag, ".vec_addr"}, 32'(bus.vec_addr),
                32'(8'(VEC_BASE) + 8'(eid)));
        end
        chk({tag, ".nest_level"}, 32'(bus.nest_level), 32'(el));
        chk({tag, ".in_service"}, 32'(bus.in_service), 32'(el != 2'd0));
        chk({tag, ".err"}, 32'(bus.err), 32'(ee));
    endtask

    task automatic step(input logic [3:0] irq, input logic mwr,
                        input logic [3:0] md, input logic ack,
                        input logic rti);
        @(negedge clk);
        bus.irq_in    = irq;
        bus.mask_wr   = mwr;
        bus.mask_data = md;
        bus.int_ack   = ack;
        bus.rti       = rti;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string pfx, input vec_t t[$]);
        foreach (t[i]) begin
            step(t[i].irq, t[i].mwr, t[i].md, t[i].ack, t[i].rti);
            check_out($sformatf("%s%0d", pfx, i), t[i].e_intr, t[i].e_id,
                      t[i].e_lvl, t[i].e_err);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b0;
        bus.irq_in    = '0;
        bus.mask_wr   = 1'b0;
        bus.mask_data = '0;
        bus.int_ack   = 1'b0;
        bus.rti       = 1'b0;

        // irq, mwr, md, ack, rti | intr, id, lvl, err
        tbl.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b1010, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 4'b1110, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 4'b1111, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 4'b1111, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));

`ifdef INTC_NEST_EN
        cfg.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 2, 1));
        cfg.push_back(mk(4'b1000, 0, 0, 0, 0, 0, 0, 2, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 2, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 2, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 3, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 1, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
`else
        cfg.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 2, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
        cfg.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1));
`endif

        #3;
        chk("rst.intr", 32'(bus.intr), 32'(0));
        chk("rst.int_id", 32'(bus.int_id), 32'(0));
        chk("rst.vec_addr", 32'(bus.vec_addr), 32'(8'(VEC_BASE)));
        chk("rst.in_service", 32'(bus.in_service), 32'(0));
        chk("rst.nest_level", 32'(bus.nest_level), 32'(0));
        chk("rst.err", 32'(bus.err), 32'(0));
        #9;
        rst = 1'b1;

        run("row", tbl);
        run("cfg", cfg);

        // Edge on the source being acked keeps it pending.
        step(4'b0100, 0, 0, 0, 0); check_out("a0", 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("a1", 1, 2, 0, 1);
        step(4'b0100, 0, 0, 1, 0); check_out("a2", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("a3", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("a4", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 1); check_out("a5", 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("a6", 1, 2, 0, 1);
        step(4'b0000, 0, 0, 1, 0); check_out("a7", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("a8", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 1); check_out("a9", 0, 0, 0, 1);

        // Stray ack ignored; repeated edges collapse to one request.
        step(4'b0000, 0, 0, 1, 0); check_out("b0", 0, 0, 0, 1);
        step(4'b0001, 0, 0, 0, 0); check_out("b1", 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("b2", 1, 0, 0, 1);
        step(4'b0001, 0, 0, 0, 0); check_out("b3", 1, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("b4", 1, 0, 0, 1);
        step(4'b0000, 0, 0, 1, 0); check_out("b5", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("b6", 0, 0, 1, 1);
        step(4'b0000, 0, 0, 0, 1); check_out("b7", 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("b8", 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("b9", 0, 0, 0, 1);

        // Asynchronous reset mid-request drops pending and restores mask.
        step(4'b0000, 1, 4'b1110, 0, 0); check_out("c0", 0, 0, 0, 1);
        step(4'b0100, 0, 0, 0, 0); check_out("c1", 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0); check_out("c2", 1, 2, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("c3.intr", 32'(bus.intr), 32'(0));
        chk("c3.int_id", 32'(bus.int_id), 32'(0));
        chk("c3.vec_addr", 32'(bus.vec_addr), 32'(8'(VEC_BASE)));
        chk("c3.err", 32'(bus.err), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        step(4'b0000, 0, 0, 0, 0); check_out("c4", 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0); check_out("c5", 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0); check_out("c6", 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0); check_out("c7", 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
